padding_ctrl: RTL and testbench

Row sequencer for the zero-padding stage of the CNN front end. It walks one frame of padded rows, fetches each interior source row from the upstream line buffer, and drives `en` and `count` of the padding datapath. It presents each padded row to the downstream convolution stage with a valid/ready handshake and signals frame completion. It sits between the input line buffer and the padding datapath and owns all row ordering for the layer.

---
 rtl/padding_ctrl_if.sv | 22 ++
 rtl/padding_ctrl.sv | 75 +++++++
 tb/tb_padding_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/padding_ctrl_if.sv
// padding_ctrl_if: start, line-buffer fetch and downstream row handshake signals of the padding row sequencer.
interface padding_ctrl_if #(parameter int CNT_W = 9);
  logic             start;
  logic             row_req;
  logic [CNT_W-1:0] row_addr;
  logic             row_valid;
  logic             row_ack;
  logic             pad_en;
  logic [CNT_W-1:0] count;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  modport master (
    input  start, row_valid, out_ready,
    output row_req, row_addr, row_ack, pad_en, count, out_valid, busy, done
  );
  modport slave (
    output start, row_valid, out_ready,
    input  row_req, row_addr, row_ack, pad_en, count, out_valid, busy, done
  );
endinterface

// File: rtl/padding_ctrl.sv
// padding_ctrl: walks one frame of zero-padded rows, fetching interior rows and handing each row downstream.
// Optional 16-bit completed-frame counter output when PADDING_CTRL_FRAME_CNT_EN is defined.
module padding_ctrl #(
  parameter int ROWS  = 416,
  parameter int CNT_W = 9
) (
  input  logic                clk,
  input  logic                reset,
  padding_ctrl_if.master      bus
`ifdef PADDING_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0]         frame_cnt
`endif
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROWS - 1);
  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d, row_addr_q;
  logic             row_req_q, out_valid_q, busy_q, done_q;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE:  if (bus.start) begin
        state_d = EMIT;
        count_d = '0;
      end
      FETCH: if (bus.row_valid) state_d = EMIT;
      EMIT:  if (bus.out_ready) begin
        if (count_q == LAST) state_d = DONE;
        else begin
          count_d = count_q + 1'b1;
          state_d = (count_q == LAST - 1'b1) ? EMIT : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      row_addr_q  <= '0;
      row_req_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      row_addr_q  <= (count_d == '0) ? '0 : count_d - 1'b1;
      row_req_q   <= state_d == FETCH;
      out_valid_q <= state_d == EMIT;
      busy_q      <= state_d == FETCH || state_d == EMIT;
      done_q      <= state_d == DONE;
    end
  end
  assign bus.row_req   = row_req_q;
  assign bus.row_addr  = row_addr_q;
  assign bus.pad_en    = out_valid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.count     = count_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  // The ack must land in the handshake cycle itself, so it follows out_ready directly.
  assign bus.row_ack   = out_valid_q & bus.out_ready & (count_q != '0) & (count_q != LAST);
`ifdef PADDING_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) frame_cnt_q <= '0;
    else if (done_q) frame_cnt_q <= frame_cnt_q + 16'd1;
  end
  assign frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_padding_ctrl.sv
// tb_padding_ctrl: directed frames checked every cycle against an abstract row-walk model plus literal pins.
module tb_padding_ctrl;
  localparam int ROWS  = 416;
  localparam int CNT_W = 9;
  logic clk = 1'b0;
  logic reset = 1'b0;
  padding_ctrl_if #(.CNT_W(CNT_W)) bus();
`ifdef PADDING_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif
  padding_ctrl #(.ROWS(ROWS), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef PADDING_CTRL_FRAME_CNT_EN
    ,
    .frame_cnt(frame_cnt)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: the frame is a walk over rows 0..ROWS-1; a row is shown once its data is in hand.
  bit m_active, m_have, m_done;
  int m_row, m_frames;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 0; m_have <= 0; m_done <= 0; m_row <= 0; m_frames <= 0;
    end else begin
      m_done <= 0;
      if (m_done) m_frames <= (m_frames + 1) & 16'hFFFF;
      if (!m_active) begin
        if (bus.start && !m_done) begin m_active <= 1; m_row <= 0; m_have <= 1; end
      end else if (!m_have) begin
        if (bus.row_valid) m_have <= 1;
      end else if (bus.out_ready) begin
        if (m_row == ROWS - 1) begin m_active <= 0; m_done <= 1; end
        else begin m_row <= m_row + 1; m_have <= (m_row + 1 == ROWS - 1); end
      end
    end
  end
  int cyc = 0, ack_cnt = 0, done_cnt = 0, done_cyc = 0, last_hs = 0, fv_cyc = 0;
  int req1 = 0, v7 = 0, ack7 = 0;
  always @(negedge clk) begin
    bit e_valid, e_ack;
    e_valid = m_active && m_have;
    e_ack   = e_valid && bus.out_ready && m_row != 0 && m_row != ROWS - 1;
    chk("row_req",   32'(bus.row_req),   32'(m_active && !m_have));
    chk("row_addr",  32'(bus.row_addr),  32'(m_row == 0 ? 0 : m_row - 1));
    chk("row_ack",   32'(bus.row_ack),   32'(e_ack));
    chk("pad_en",    32'(bus.pad_en),    32'(e_valid));
    chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
    chk("count",     32'(bus.count),     32'(m_row));
    chk("busy",      32'(bus.busy),      32'(m_active));
    chk("done",      32'(bus.done),      32'(m_done));
`ifdef PADDING_CTRL_FRAME_CNT_EN
    chk("frame_cnt", 32'(frame_cnt),     32'(m_frames));
`endif
    cyc++;
    if (bus.row_ack) ack_cnt++;
    if (bus.done) begin done_cnt++; done_cyc = cyc; end
    if (bus.out_valid && bus.out_ready) last_hs = cyc;
    if (bus.out_valid && bus.count == 0 && fv_cyc == 0) fv_cyc = cyc;
    if (bus.row_req && bus.count == 1 && bus.row_addr == 0 && !bus.pad_en) req1++;
    if (bus.out_valid && bus.count == 7 && bus.row_addr == 6 && bus.pad_en) v7++;
    if (bus.row_ack && bus.count == 7) ack7++;
  end
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  task automatic pulse_start;
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
  endtask
  // kind: 0 row_req, 1 count==r, 2 out_valid at count==r, 3 done
  task automatic wait_for(input int kind, input int r);
    int n = 0;
    bit hit = 0;
    while (!hit && n < 3000) begin
      case (kind)
        0: hit = bus.row_req;
        1: hit = bus.count == r;
        2: hit = bus.out_valid && bus.count == r;
        default: hit = bus.done;
      endcase
      if (!hit) begin step; n++; end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL wait kind=%0d row=%0d: got timeout expected event", kind, r);
    end
  endtask
  int a0, d0, r0, v0, k0;
  initial begin
    bus.start = 0; bus.row_valid = 1; bus.out_ready = 1;
    repeat (2) step;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    reset = 1;
    step;
    // frame 1: zero-wait buffer, out_ready high
    a0 = ack_cnt; d0 = done_cnt;
    pulse_start;
    chk("first_valid", 32'(bus.out_valid), 1);
    chk("first_count", 32'(bus.count), 0);
    chk("first_no_req", 32'(bus.row_req), 0);
    wait_for(3, 0);
    step;
    chk("f1_acks", 32'(ack_cnt - a0), 414);
    chk("f1_dones", 32'(done_cnt - d0), 1);
    chk("f1_span", 32'(last_hs - fv_cyc + 1), 830);
    chk("f1_done_gap", 32'(done_cyc - last_hs), 1);
`ifdef PADDING_CTRL_FRAME_CNT_EN
    chk("frame_cnt_1", 32'(frame_cnt), 1);
`endif
    // frame 2: slow fetch on row 1, stall on row 7, ignored starts
    r0 = req1; v0 = v7; k0 = ack7;
    bus.row_valid = 0;
    pulse_start;
    wait_for(0, 0);
    repeat (5) step;
    bus.row_valid = 1;
    wait_for(1, 7);
    bus.out_ready = 0;
    wait_for(2, 7);
    repeat (4) step;
    bus.out_ready = 1;
    wait_for(1, 100);
    pulse_start;
    wait_for(3, 0);
    bus.start = 1;
    step;
    bus.start = 0;
    step;
    chk("done_start_busy", 32'(bus.busy), 0);
    chk("done_start_valid", 32'(bus.out_valid), 0);
    chk("idle_count_hold", 32'(bus.count), ROWS - 1);
    chk("row1_req_cycles", 32'(req1 - r0), 6);
    chk("row7_valid_cycles", 32'(v7 - v0), 5);
    chk("row7_acks", 32'(ack7 - k0), 1);
`ifdef PADDING_CTRL_FRAME_CNT_EN
    chk("frame_cnt_2", 32'(frame_cnt), 2);
`endif
    // frame 3 back-to-back
    pulse_start;
    wait_for(3, 0);
    step;
`ifdef PADDING_CTRL_FRAME_CNT_EN
    chk("frame_cnt_3", 32'(frame_cnt), 3);
`endif
    // frame 4: reset during EMIT at row 200
    pulse_start;
    wait_for(2, 200);
    #1 reset = 0;
    #1;
    chk("mid_rst_row_req", 32'(bus.row_req), 0);
    chk("mid_rst_row_addr", 32'(bus.row_addr), 0);
    chk("mid_rst_row_ack", 32'(bus.row_ack), 0);
    chk("mid_rst_pad_en", 32'(bus.pad_en), 0);
    chk("mid_rst_count", 32'(bus.count), 0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    a0 = ack_cnt; d0 = done_cnt;
    repeat (3) step;
    reset = 1;
    repeat (5) step;
    chk("post_rst_acks", 32'(ack_cnt - a0), 0);
    chk("post_rst_dones", 32'(done_cnt - d0), 0);
    pulse_start;
    chk("restart_count", 32'(bus.count), 0);
    chk("restart_no_req", 32'(bus.row_req), 0);
    chk("restart_valid", 32'(bus.out_valid), 1);
    wait_for(3, 0);
    step;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
